tx_serial_config: RTL

TX_SERIAL_CONFIG -- requirements
Module: tx_serial_config

---
 rtl/tx_serial_config.sv | 118 +++++++++++
 1 files changed

// File: rtl/tx_serial_config.sv
// Configurable async-serial transmitter: start, LSB-first data, optional parity, 1-2 stops.
// Frame starts 2 cycles after partida is accepted; requests outside INICIAL are dropped (no queueing).
module tx_serial_config #(
    parameter int DATA_BITS = 7,
    parameter int PARITY    = 2,
    parameter int STOP_BITS = 1,
    parameter int DIVISOR   = 434
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 partida,
    input  logic [DATA_BITS-1:0] dados,
    output logic                 saida_serial,
    output logic                 pronto,
    output logic                 ocupado,
    output logic [3:0]           db_estado
);

    localparam int F  = 1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
    localparam int TW = $clog2(DIVISOR);
    localparam logic [TW-1:0] TICK_LAST = TW'(DIVISOR - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(F - 1);

    typedef enum logic [3:0] {
        INICIAL     = 4'd0,
        PREPARACAO  = 4'd1,
        TRANSMISSAO = 4'd2,
        FINAL       = 4'd3
    } estado_t;

    estado_t              estado_q;
    logic [DATA_BITS-1:0] dado_q;
    logic [F-2:0]         sr_q;
    logic [TW-1:0]        tick_q;
    logic [3:0]           bit_q;
    logic                 saida_q;
    logic                 pronto_q;
    logic                 ocupado_q;
    logic                 paridade_d;
    logic [F-1:0]         frame_d;

    always_comb begin
        paridade_d = (PARITY == 1) ? ^dado_q : ~^dado_q;
        frame_d    = '1;
        frame_d[0] = 1'b0;
        frame_d[DATA_BITS:1] = dado_q;
        if (PARITY != 0) begin
            frame_d[DATA_BITS+1] = paridade_d;
        end
    end

    // sr_q holds the bits still to be sent after the one currently on the line.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q  <= INICIAL;
            dado_q    <= '0;
            sr_q      <= '1;
            tick_q    <= '0;
            bit_q     <= '0;
            saida_q   <= 1'b1;
            pronto_q  <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            case (estado_q)
                INICIAL: begin
                    saida_q  <= 1'b1;
                    pronto_q <= 1'b0;
                    if (partida) begin
                        dado_q    <= dados;
                        ocupado_q <= 1'b1;
                        estado_q  <= PREPARACAO;
                    end
                end
                PREPARACAO: begin
                    sr_q     <= frame_d[F-1:1];
                    saida_q  <= frame_d[0];
                    tick_q   <= '0;
                    bit_q    <= '0;
                    estado_q <= TRANSMISSAO;
                end
                TRANSMISSAO: begin
                    if (tick_q == TICK_LAST) begin
                        tick_q  <= '0;
                        bit_q   <= bit_q + 4'd1;
                        sr_q    <= {1'b1, sr_q[F-2:1]};
                        saida_q <= sr_q[0];
                        if (bit_q == BIT_LAST) begin
                            saida_q  <= 1'b1;
                            pronto_q <= 1'b1;
                            estado_q <= FINAL;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                FINAL: begin
                    saida_q   <= 1'b1;
                    pronto_q  <= 1'b0;
                    ocupado_q <= 1'b0;
                    sr_q      <= '1;
                    estado_q  <= INICIAL;
                end
                default: begin
                    saida_q   <= 1'b1;
                    pronto_q  <= 1'b0;
                    ocupado_q <= 1'b0;
                    estado_q  <= INICIAL;
                end
            endcase
        end
    end

    assign saida_serial = saida_q;
    assign pronto       = pronto_q;
    assign ocupado      = ocupado_q;
    assign db_estado    = estado_q;

endmodule
